// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
// Helper functions work on fixed maximum widths; callers cast to their own sizes.
package arbiter_pkg;

  localparam int MAX_PORTS    = 64;
  localparam int MAX_IDX_W    = 6;
  localparam int MAX_WEIGHT_W = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_e;

  function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_PORTS-1:0] vec);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (vec[i]) idx = idx | MAX_IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [MAX_WEIGHT_W-1:0] eff_weight(input logic [MAX_WEIGHT_W-1:0] w);
    return (w == '0) ? MAX_WEIGHT_W'(1) : w;
  endfunction

endpackage

// File: rtl/arbiter_wrr_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, else wrap
// to the lowest set request.
module rr_pick
  import arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 9,
  parameter int SEL_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] request,
  input  logic [SEL_W-1:0]     ptr,
  output logic                 found,
  output logic [SEL_W-1:0]     idx,
  output logic [NUM_PORTS-1:0] pick
);

  logic [NUM_PORTS-1:0] belowPtr;
  logic [NUM_PORTS-1:0] upper;
  logic [NUM_PORTS-1:0] cand;
  logic [MAX_PORTS-1:0] pickWide;

  // Mask off ports below ptr; if none remain, the lowest overall request wins.
  always_comb begin
    belowPtr = (NUM_PORTS'(1) << ptr) - NUM_PORTS'(1);
    upper    = request & ~belowPtr;
    cand     = (upper != '0) ? upper : request;
    pick     = cand & (~cand + NUM_PORTS'(1));
    found    = |request;
    pickWide = MAX_PORTS'(pick);
    idx      = SEL_W'(onehot_to_idx(pickWide));
  end

endmodule

// File: rtl/arbiter_wrr.sv
// Weighted round-robin arbiter: each grant lasts up to the port's weight in cycles,
// hold extends a grant while its request stays high, handoff has no idle cycle.
module arbiter_wrr
  import arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 9,
  parameter int WEIGHT_W  = 4,
  parameter int SEL_W     = $clog2(NUM_PORTS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          request,
  input  logic [NUM_PORTS*WEIGHT_W-1:0] weight,
  input  logic                          hold,
  output logic [NUM_PORTS-1:0]          grant,
  output logic [SEL_W-1:0]              select,
  output logic                          active
);

  state_e               state_q, state_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]     select_q, select_d;
  logic                 active_q, active_d;
  logic [SEL_W-1:0]     ptr_q, ptr_d;
  logic [WEIGHT_W-1:0]  credit_q, credit_d;

  logic                 found;
  logic [SEL_W-1:0]     pickIdx;
  logic [NUM_PORTS-1:0] pick;
  logic [WEIGHT_W-1:0]  weightArr [NUM_PORTS];
  logic [WEIGHT_W-1:0]  effWeight;
  logic                 keep;
  logic [SEL_W-1:0]     nextPtr;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_weight
    assign weightArr[g] = weight[g*WEIGHT_W +: WEIGHT_W];
  end

  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .SEL_W     (SEL_W)
  ) u_pick (
    .request (request),
    .ptr     (ptr_q),
    .found   (found),
    .idx     (pickIdx),
    .pick    (pick)
  );

  // The owner keeps the bus while requesting and either under quota or holding.
  always_comb begin
    effWeight = WEIGHT_W'(eff_weight(MAX_WEIGHT_W'(weightArr[select_q])));
    keep      = (state_q == ST_OWN) && request[select_q] &&
                ((credit_q < effWeight) || hold);
    nextPtr   = (pickIdx == SEL_W'(NUM_PORTS - 1)) ? '0 : pickIdx + SEL_W'(1);
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    select_d = select_q;
    active_d = active_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d  = ST_OWN;
          grant_d  = pick;
          select_d = pickIdx;
          active_d = 1'b1;
          credit_d = WEIGHT_W'(1);
          ptr_d    = nextPtr;
        end
      end
      ST_OWN: begin
        if (keep) begin
          if (credit_q != '1) credit_d = credit_q + WEIGHT_W'(1);
        end else if (found) begin
          // Pointer already sits past the owner, so a lone owner is simply re-granted.
          grant_d  = pick;
          select_d = pickIdx;
          active_d = 1'b1;
          credit_d = WEIGHT_W'(1);
          ptr_d    = nextPtr;
        end else begin
          state_d  = ST_IDLE;
          grant_d  = '0;
          active_d = 1'b0;
          credit_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      select_q <= '0;
      active_q <= 1'b0;
      ptr_q    <= '0;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      select_q <= select_d;
      active_q <= active_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
    end
  end

  assign grant  = grant_q;
  assign select = select_q;
  assign active = active_q;

endmodule

// File: tb/tb_arbiter_wrr.sv
// Self-checking bench for arbiter_wrr: directed scenarios plus randomized traffic,
// all compared against a behavioural round-robin model built from integers.
module tb_arbiter_wrr;

  localparam int N  = 9;
  localparam int WW = 4;
  localparam int SW = $clog2(N);

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    request;
  logic [N*WW-1:0] weight;
  logic            hold;
  logic [N-1:0]    grant;
  logic [SW-1:0]   select;
  logic            active;

  int assertCount = 0;
  int failCount   = 0;

  // Reference model state: owner index (-1 = none), pointer, credit, last select.
  int mOwner  = -1;
  int mPtr    = 0;
  int mCredit = 0;
  int mSelect = 0;

  arbiter_wrr #(
    .NUM_PORTS (N),
    .WEIGHT_W  (WW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .request (request),
    .weight  (weight),
    .hold    (hold),
    .grant   (grant),
    .select  (select),
    .active  (active)
  );

  always #5 clk = ~clk;

  function automatic int effW(input int p);
    int w;
    w = int'(weight[p*WW +: WW]);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic logic [N-1:0] expGrant();
    return (mOwner < 0) ? '0 : (N'(1) << mOwner);
  endfunction

  function automatic logic expActive();
    return (mOwner >= 0);
  endfunction

  task automatic modelStep();
    int  found;
    int  q;
    bit  keep;
    if (rst) begin
      mOwner = -1; mPtr = 0; mCredit = 0; mSelect = 0;
    end else begin
      keep = (mOwner >= 0) && request[mOwner] && ((mCredit < effW(mOwner)) || hold);
      if (keep) begin
        if (mCredit < (1 << WW) - 1) mCredit++;
      end else begin
        found = -1;
        for (int k = 0; k < N; k++) begin
          q = (mPtr + k) % N;
          if (found < 0 && request[q]) found = q;
        end
        if (found >= 0) begin
          mOwner = found; mSelect = found; mCredit = 1; mPtr = (found + 1) % N;
        end else begin
          mOwner = -1; mCredit = 0;
        end
      end
    end
  endtask

  task automatic advanceCycle();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic setWeight(input int p, input int w);
    weight[p*WW +: WW] = WW'(w);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; request = '1; hold = 1'b0;
    for (int p = 0; p < N; p++) setWeight(p, 1);
    for (int c = 0; c < 3; c++) begin
      advanceCycle();
      assertCount++;
      if (grant !== '0 || select !== '0 || active !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL reset_hold c%0d: got grant=%b select=%0d active=%b, want 0/0/0",
                 c, grant, select, active);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    advanceCycle();
    assertCount++;
    if (grant !== 9'b000000001 || select !== SW'(0) || active !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL reset_first_grant: got grant=%b select=%0d active=%b, want port 0",
               grant, select, active);
    end
  endtask

  task automatic test_rotation();
    @(negedge clk);
    for (int p = 0; p < N; p++) setWeight(p, 2);
    request = 9'b100000001;
    for (int c = 0; c < 12; c++) begin
      advanceCycle();
      assertCount++;
      if (grant !== expGrant() || select !== SW'(mSelect) || active !== 1'b1) begin
        failCount++;
        $display("[TB] FAIL rotation c%0d: got grant=%b select=%0d active=%b, want grant=%b select=%0d active=1",
                 c, grant, select, active, expGrant(), mSelect);
      end
    end
  endtask

  task automatic test_skewed();
    @(negedge clk);
    setWeight(1, 4); setWeight(2, 1);
    request = 9'b000000110;
    for (int c = 0; c < 40; c++) begin
      if (c == 20) begin
        @(negedge clk);
        setWeight(2, 0);
      end
      advanceCycle();
      assertCount++;
      if (grant !== expGrant() || select !== SW'(mSelect) || active !== expActive()) begin
        failCount++;
        $display("[TB] FAIL skewed c%0d: got grant=%b select=%0d active=%b, want grant=%b select=%0d",
                 c, grant, select, active, expGrant(), mSelect);
      end
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    request = '0;
    advanceCycle();
    @(negedge clk);
    setWeight(3, 1);
    request = 9'b000001000; hold = 1'b1;
    advanceCycle();
    assertCount++;
    if (grant !== 9'b000001000) begin
      failCount++;
      $display("[TB] FAIL hold_start: got grant=%b, want %b", grant, 9'b000001000);
    end
    @(negedge clk);
    request = 9'b000101000;
    for (int c = 0; c < 6; c++) begin
      advanceCycle();
      assertCount++;
      if (grant !== 9'b000001000 || grant !== expGrant() || select !== SW'(3)) begin
        failCount++;
        $display("[TB] FAIL hold_keep c%0d: got grant=%b select=%0d, want grant=%b select=3",
                 c, grant, select, 9'b000001000);
      end
    end
    @(negedge clk);
    hold = 1'b0;
    advanceCycle();
    assertCount++;
    if (grant !== 9'b000100000 || select !== SW'(5) || active !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL hold_release: got grant=%b select=%0d active=%b, want port 5",
               grant, select, active);
    end
  endtask

  task automatic test_lone_requester();
    @(negedge clk);
    setWeight(5, 2);
    request = 9'b000100000;
    for (int c = 0; c < 8; c++) begin
      advanceCycle();
      assertCount++;
      if (grant !== 9'b000100000 || active !== 1'b1 || grant !== expGrant()) begin
        failCount++;
        $display("[TB] FAIL lone_regrant c%0d: got grant=%b active=%b, want grant=%b active=1",
                 c, grant, active, 9'b000100000);
      end
    end
    @(negedge clk);
    request = '0;
    advanceCycle();
    assertCount++;
    if (grant !== '0 || active !== 1'b0 || select !== SW'(5)) begin
      failCount++;
      $display("[TB] FAIL lone_drop: got grant=%b select=%0d active=%b, want 0/5/0",
               grant, select, active);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (c % 60 == 0) weight = (N*WW)'({$urandom(), $urandom()});
      request = N'($urandom()) & N'($urandom());
      hold    = ($urandom_range(0, 3) == 0);
      rst     = ($urandom_range(0, 99) == 0);
      advanceCycle();
      assertCount++;
      if (grant !== expGrant() || select !== SW'(mSelect) || active !== expActive()) begin
        failCount++;
        $display("[TB] FAIL random c%0d: got grant=%b select=%0d active=%b, want grant=%b select=%0d active=%b",
                 c, grant, select, active, expGrant(), mSelect, expActive());
      end
    end
    @(negedge clk);
    rst = 1'b0; hold = 1'b0;
  endtask

  task automatic test_mid_reset();
    bit reached;
    @(negedge clk);
    for (int p = 0; p < N; p++) setWeight(p, 1);
    request = '1; hold = 1'b0;
    reached = 1'b0;
    for (int c = 0; c < 30 && !reached; c++) begin
      advanceCycle();
      if (grant === 9'b010000000) reached = 1'b1;
    end
    assertCount++;
    if (!reached) begin
      failCount++;
      $display("[TB] FAIL mid_reset_reach: port 7 never granted within 30 cycles, last grant=%b", grant);
    end
    @(negedge clk);
    rst = 1'b1;
    advanceCycle();
    assertCount++;
    if (grant !== '0 || select !== '0 || active !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL mid_reset_clear: got grant=%b select=%0d active=%b, want 0/0/0",
               grant, select, active);
    end
    @(negedge clk);
    rst = 1'b0;
    advanceCycle();
    assertCount++;
    if (grant !== 9'b000000001 || select !== SW'(0) || active !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL mid_reset_regrant: got grant=%b select=%0d active=%b, want port 0",
               grant, select, active);
    end
  endtask

  initial begin
    rst = 1'b1; request = '1; hold = 1'b0; weight = '0;
    test_reset();
    test_rotation();
    test_skewed();
    test_hold();
    test_lone_requester();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
